// File: rtl/skidbuf.sv
// skidbuf: two-entry elastic pipeline register with registered InReady/OutValid/OutData.
// Optional synchronous flush port is compiled in when SKIDBUF_FLUSH_EN is defined.
module skidbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SKIDBUF_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy
);

  // state | meaning
  // EMPTY | no beat buffered; main and skid both free
  // ONE   | main holds the oldest beat; skid free, InReady=1
  // TWO   | main and skid both full; InReady=0 until main is consumed
  // The encoding is {SkidValid, MainValid}; 2'b10 is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [1:0]       r_occupancy;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic             w_flush;
  logic             w_in_fire;
  logic             w_out_fire;

`ifdef SKIDBUF_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_fire  = InValid & r_in_ready;
  assign w_out_fire = r_state[0] & OutReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_occupancy <= 2'd0;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (w_flush) begin
      // Data registers keep their contents; only the valid state is dropped.
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= InData;
            r_state     <= ONE;
            r_occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data <= InData;
          end else if (w_in_fire) begin
            r_skid_data <= InData;
            r_state     <= TWO;
            r_in_ready  <= 1'b0;
            r_occupancy <= 2'd2;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
            r_occupancy <= 2'd0;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
            r_state     <= ONE;
            r_in_ready  <= 1'b1;
            r_occupancy <= 2'd1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_occupancy <= 2'd0;
        end
      endcase
    end
  end

  assign InReady   = r_in_ready;
  assign OutValid  = r_state[0];
  assign OutData   = r_main_data;
  assign Occupancy = r_occupancy;

endmodule

// File: tb/tb_skidbuf.sv
// tb_skidbuf: scoreboard bench for skidbuf; a FIFO-of-accepted-beats model predicts every output.
// Define SKIDBUF_FLUSH_EN on both files to exercise the flush port.
module tb_skidbuf;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_drv;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic [1:0]       Occupancy;

  logic [WIDTH-1:0] exp_q[$];
  int n_vec    = 0;
  int n_err    = 0;
  int n_popped = 0;

  skidbuf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SKIDBUF_FLUSH_EN
    .flush     (flush_drv),
`endif
    .InValid   (InValid),
    .InReady   (InReady),
    .InData    (InData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutData   (OutData),
    .Occupancy (Occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every consumer transfer must match the oldest accepted beat.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (OutValid === 1'b1 && OutReady === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", OutData);
        end else begin
          chk("out_beat", {24'd0, OutData}, {24'd0, exp_q.pop_front()});
          n_popped++;
        end
      end
      chk("state_10_absent", {31'd0, (InReady === 1'b0 && OutValid === 1'b0)}, 32'd0);
    end
  end

  // One clock: the model records what the edge will accept, then the DUT is compared after the edge.
  task automatic step();
    @(negedge clk);
    if (reset || flush_drv) exp_q.delete();
    else if (InValid && InReady) exp_q.push_back(InData);
    @(posedge clk);
    #1;
    chk("occupancy", {30'd0, Occupancy}, exp_q.size());
    chk("out_valid", {31'd0, OutValid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("out_data_head", {24'd0, OutData}, {24'd0, exp_q[0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int accepted;
    int cycles;
    reset = 1'b1; flush_drv = 1'b0;
    InValid = 1'b1; InData = 8'hAA; OutReady = 1'b0;
    step(); step();
    reset = 1'b0; InValid = 1'b0;
    chk("reset_out_data",  {24'd0, OutData}, 32'h00);
    chk("reset_out_valid", {31'd0, OutValid}, 32'd0);
    chk("reset_in_ready",  {31'd0, InReady}, 32'd1);
    chk("reset_occupancy", {30'd0, Occupancy}, 32'd0);
    step();

    // Streaming at full rate
    base = n_popped;
    OutReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      InValid = 1'b1; InData = i[7:0];
      step();
      chk("stream_in_ready", {31'd0, InReady}, 32'd1);
    end
    InValid = 1'b0;
    step(); step();
    chk("stream_count", n_popped - base, 32'd16);

    // Stall with skid fill
    base = n_popped;
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'h11; step();
    InData = 8'h22; step();
    chk("stall_in_ready_low", {31'd0, InReady}, 32'd0);
    InValid = 1'b0;
    step(); step();
    chk("stall_hold", {24'd0, OutData}, 32'h11);
    OutReady = 1'b1;
    step();
    chk("stall_in_ready_back", {31'd0, InReady}, 32'd1);
    step();
    chk("stall_count", n_popped - base, 32'd2);

    // Reset with two beats buffered
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'h33; step();
    InData = 8'h44; step();
    InValid = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    base = n_popped;
    InValid = 1'b1; InData = 8'h55; step();
    InValid = 1'b0; OutReady = 1'b1; step(); step();
    chk("midreset_count", n_popped - base, 32'd1);

`ifdef SKIDBUF_FLUSH_EN
    base = n_popped;
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'h5A; step();
    InData = 8'h5B; step();
    flush_drv = 1'b1; InData = 8'h66; step();
    flush_drv = 1'b0; InValid = 1'b0;
    chk("flush_occupancy", {30'd0, Occupancy}, 32'd0);
    chk("flush_in_ready", {31'd0, InReady}, 32'd1);
    InValid = 1'b1; InData = 8'h77; step();
    flush_drv = 1'b1; InData = 8'h66; step();
    flush_drv = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    step(); step();
    chk("flush_count", n_popped - base, 32'd0);
`endif

    // Random backpressure
    base = n_popped;
    accepted = 0; cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      InValid  = 1'($urandom_range(0, 1));
      InData   = 8'($urandom);
      OutReady = 1'($urandom_range(0, 1));
      if (InValid && InReady) accepted++;
      step();
      cycles++;
    end
    chk("random_accepted", accepted, 32'd1000);
    InValid = 1'b0; OutReady = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      step();
      cycles++;
    end
    chk("random_drained", exp_q.size(), 32'd0);
    chk("random_count", n_popped - base, 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
